mult_sequencer: RTL
===================

// Module: mult_sequencer
// PURPOSE
//  Control FSM for the sequential signed shift-add multiplier datapath.
//  Turns a raw start level (switch/button) into one start tick, then sequences
//  load -> WIDTH add/shift steps -> sign fix-up -> done.
//  Datapath holds |A|, |B| and the product; this block only issues strobes and tracks sign/count.
// PARAMETERS
//  WIDTH  8  operand width in bits; CALC runs exactly WIDTH cycles
//  CNT_W  $clog2(WIDTH+1)  step counter width (derived, not overridden)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  start_lvl  in   1      raw start level; a 0->1 transition requests a multiply
//  a_sign     in   1      multiplicand MSB, sampled in LOAD
//  b_sign     in   1      multiplier MSB, sampled in LOAD
//  mplr_lsb   in   1      current LSB of datapath multiplier shift register
//  load       out  1      datapath loads |A|,|B|, clears product
//  add_en     out  1      datapath adds multiplicand into product this cycle
//  shift_en   out  1      datapath shifts multiplicand left / multiplier right
//  negate_en  out  1      datapath two's-complements the product
//  busy       out  1      high in LOAD, CALC, FIXUP
//  done       out  1      product valid; held until the next accepted start
//  step_cnt   out  CNT_W  CALC steps completed (0..WIDTH)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, all outputs 0, step_cnt=0, sign reg 0,
//    edge-detector history 0. Release is synchronous to clk.
//  - start_tick: 1-cycle pulse, cycle after start_lvl sampled 1 with history 0.
//    A level already high at reset release yields one tick (history resets to 0).
//  - States: IDLE, LOAD, CALC, FIXUP, DONE.
//    IDLE : tick -> LOAD; else stay.
//    LOAD : load=1; sign <= a_sign^b_sign; step_cnt<=0; -> CALC.
//    CALC : shift_en=1; add_en=mplr_lsb (only combinational output);
//           step_cnt++; when step_cnt==WIDTH-1 -> FIXUP.
//    FIXUP: negate_en=sign; -> DONE.
//    DONE : done=1; tick -> LOAD (done drops in LOAD); else stay.
//  - Ticks in LOAD/CALC/FIXUP are dropped, not queued.
//  - Timing from tick cycle t: LOAD t+1, CALC t+2..t+WIDTH+1,
//    FIXUP t+WIDTH+2, done first high t+WIDTH+3. busy high WIDTH+2 cycles.
//  - step_cnt reads WIDTH in FIXUP/DONE; never wraps; cleared in LOAD.
//  - Outputs other than add_en are registered/state-decoded; never X after reset.
//  - rst asserted mid-operation: immediate return to IDLE, strobes low same
//    instant; no completion or done pulse.
//  - a_sign/b_sign ignored outside LOAD.
// STRUCTURE
//  - Shared package mult_pkg: state encoding constants (IDLE..DONE, 3-bit),
//    default WIDTH. Datapath and bench both use it.
//  - One sub-module: existing rising_edge_detector (clk, rst, lvl, tck);
//    drive its reset with ~rst, since it resets active-high.
//  - FSM plus counter in this file; no other hierarchy.
// TESTING  (WIDTH=8, clk period 50)
//  - Reset: rst=0 at t0, start_lvl toggling -> all outputs 0, no state change.
//  - -3 x 5: a_sign=1,b_sign=0, mplr_lsb seq 1,0,1,0,0,0,0,0 -> load at t+1,
//    add_en in CALC steps 0 and 2 only, shift_en 8 cycles, negate_en=1 at t+10,
//    done at t+11.
//  - -3 x -5: both signs 1 -> negate_en=0 in FIXUP; otherwise identical timing.
//  - start_lvl 0,1,0,0,1,1,1,1,0,1 during busy -> only first edge accepted;
//    busy stays exactly 10 cycles; no restart.
//  - From DONE, new start_lvl edge -> done falls in LOAD, step_cnt back to 0,
//    second product sequenced.
//  - rst pulsed low during CALC step 4 -> busy/strobes low at once,
//    state IDLE, step_cnt 0, done never asserted.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the signed shift-add multiplier.
// State encoding and default operand width.
package mult_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/rising_edge_detector.sv
// Registered 0->1 detector for a raw level input.
// Active-high async reset; history clears to 0.
module rising_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic tck
);

  logic hist;

  // history register and one-cycle tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 1'b0;
      tck  <= 1'b0;
    end else begin
      hist <= lvl;
      tck  <= lvl & ~hist;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM for the sequential signed shift-add multiplier.
// Issues load/add/shift/negate strobes and tracks sign and step count.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_lvl,
  input  logic             a_sign,
  input  logic             b_sign,
  input  logic             mplr_lsb,
  output logic             load,
  output logic             add_en,
  output logic             shift_en,
  output logic             negate_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_cnt
);

  state_t     state;
  state_t     nxt;
  logic       sign;
  logic       tick;
  logic       rst_hi;
  logic       last;

  assign rst_hi = ~rst;
  assign last   = (step_cnt == CNT_W'(WIDTH - 1));

  rising_edge_detector u_edge (
    .clk (clk),
    .rst (rst_hi),
    .lvl (start_lvl),
    .tck (tick)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // next state; ticks outside IDLE/DONE are dropped
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (tick) nxt = LOAD;
      LOAD:    nxt = CALC;
      CALC:    if (last) nxt = FIXUP;
      FIXUP:   nxt = DONE;
      DONE:    if (tick) nxt = LOAD;
      default: nxt = IDLE;
    endcase
  end

  // state-decoded strobes; add_en follows the multiplier LSB
  always_comb begin
    load      = 1'b0;
    add_en    = 1'b0;
    shift_en  = 1'b0;
    negate_en = 1'b0;
    done      = 1'b0;
    unique case (state)
      LOAD: load = 1'b1;
      CALC: begin
        shift_en = 1'b1;
        add_en   = mplr_lsb;
      end
      FIXUP:   negate_en = sign;
      DONE:    done = 1'b1;
      default: ;
    endcase
    busy = (state == LOAD) | (state == CALC) |
           (state == FIXUP);
  end

  // step counter: cleared on entry to LOAD so it reads 0 there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                step_cnt <= '0;
    else if (nxt == LOAD)    step_cnt <= '0;
    else if (state == CALC)  step_cnt <= step_cnt + 1'b1;
  end

  // result sign captured while operands are loaded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               sign <= 1'b0;
    else if (state == LOAD) sign <= a_sign ^ b_sign;
  end

endmodule
